row_clear: RTL and testbench
============================

ROW_CLEAR -- requirements
Module: row_clear

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port: resetn  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-003 SHALL have port: start  input  1  single-cycle request to scan the board after a piece locks.
REQ-004 SHALL have port: ram_q  input  6  board RAM read data; valid the cycle after ram_addr is presented.
REQ-005 SHALL have port: ram_addr  output  8  board RAM address.
REQ-006 SHALL have port: ram_data  output  6  board RAM write data.
REQ-007 SHALL have port: ram_wren  output  1  board RAM write enable.
REQ-008 SHALL have port: busy  output  1  high from the cycle after start is accepted until done.
REQ-009 SHALL have port: done  output  1  one-cycle pulse when the operation completes; the downstream redraw stage uses it as its enable.
REQ-010 SHALL have port: rows_cleared  output  3  number of rows removed by the last operation; held until the next start.

Function
REQ-011 SHALL model the board as 10 columns x 24 rows: rows 0-3 hidden, row 23 bottom; cell address = y*10 + x (0-239); colour 0 = empty.
REQ-012 SHALL implement the states IDLE, SCAN_RD, SCAN_CHK, SHIFT_RD, SHIFT_WR, CLEAR_TOP, FINISH.
REQ-013 In IDLE, when start=1: SHALL set row pointer to 23, column to 0, and rows_cleared to 0, then enter SCAN_RD; busy rises on the next cycle.
REQ-014 SHALL ignore start whenever it is not in IDLE.
REQ-015 SCAN_RD: SHALL drive ram_addr = row*10+col with ram_wren=0, then enter SCAN_CHK.
REQ-016 SCAN_CHK: if ram_q==0, the row is not full; SHALL enter FINISH if row==0, else decrement row, set col=0, and enter SCAN_RD (early exit).
REQ-017 SCAN_CHK: if ram_q!=0 and col<9, SHALL increment col and enter SCAN_RD; if col==9, the row is full; SHALL set shift destination = row, col=0, and enter SHIFT_RD.
REQ-018 SHIFT_RD: SHALL read address (dst-1)*10+col; SHIFT_WR SHALL then write ram_q to dst*10+col with ram_wren=1 for exactly that cycle.
REQ-019 After SHIFT_WR with col<9, SHALL increment col and enter SHIFT_RD; with col==9, SHALL decrement dst, set col=0, and enter SHIFT_RD while dst>1, else enter CLEAR_TOP.
REQ-020 CLEAR_TOP: SHALL write 0 to addresses 0..9 on 10 consecutive cycles, ram_wren=1, then increment rows_cleared (saturating at 7) and re-enter SCAN_RD for the same row pointer, col=0.
REQ-021 Full row at row 0: SHALL skip shifting, go directly to CLEAR_TOP, then FINISH after the rescan of row 0.
REQ-022 Timing: an empty-board operation SHALL take exactly 48 cycles from start-accepted to done; a full-row removal at row r SHALL cost 20 + 20*r + 10 cycles before the rescan.
REQ-023 FINISH: SHALL pulse done for one cycle, drop busy in the same cycle, and return to IDLE.
REQ-024 ram_wren SHALL be 0 in every state except SHIFT_WR and CLEAR_TOP; ram_data SHALL be ram_q in SHIFT_WR, 0 in CLEAR_TOP, and 0 otherwise.
REQ-025 Row and column arithmetic SHALL be unsigned; the row pointer SHALL never wrap below 0 and the column SHALL never exceed 9.

Reset
REQ-026 With resetn=0 at a clock edge, SHALL enter IDLE; busy=0, done=0, ram_wren=0, ram_addr=0, ram_data=0, rows_cleared=0.
REQ-027 Reset mid-operation SHALL abort immediately with no further writes; partially shifted RAM contents are left as-is.

Structure
REQ-028 BOARD_W=10, BOARD_H=24, HIDDEN_ROWS=4, EMPTY_COLOUR=0 and the state encoding SHALL live in shared package tetris_pkg.
REQ-029 Address generation SHALL reuse the existing coord_to_addr sub-module (X,Y to 8-bit address), one instance, muxed between the scan/read and write coordinates.

Verification
REQ-030 Empty board, start -> no ram_wren, done exactly 48 cycles after start accepted, rows_cleared=0.
REQ-031 Row 23 full (colour 5), row 22 holds colour 3 at x=0 only -> row 23 then holds colour 3 at x=0 only, rows 0 and 22 are all 0, rows_cleared=1.
REQ-032 Rows 20-23 all full, row 19 = colour 2 at x=4 -> cell (4,23)=2, all other cells 0, rows_cleared=4.
REQ-033 Row 0 alone full -> row 0 is cleared, no SHIFT writes occur, rows_cleared=1.
REQ-034 start pulsed again while busy -> ignored; single done pulse; result identical to a single start.
REQ-035 resetn=0 during SHIFT_WR -> next cycle: busy=0, ram_wren=0, state IDLE; a subsequent start runs normally.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared board geometry and row-clear FSM encoding for the tetris playfield logic.
package tetris_pkg;

  localparam int BOARD_W     = 10;
  localparam int BOARD_H     = 24;
  localparam int HIDDEN_ROWS = 4;

  localparam logic [5:0] EMPTY_COLOUR = 6'd0;
  localparam logic [3:0] LAST_COL     = 4'(BOARD_W - 1);
  localparam logic [4:0] BOTTOM_ROW   = 5'(BOARD_H - 1);
  localparam logic [2:0] MAX_CLEARED  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SCAN_RD   = 3'd1,
    ST_SCAN_CHK  = 3'd2,
    ST_SHIFT_RD  = 3'd3,
    ST_SHIFT_WR  = 3'd4,
    ST_CLEAR_TOP = 3'd5,
    ST_FINISH    = 3'd6
  } rc_state_e;

endpackage

// File: rtl/coord_to_addr.sv
// Board cell (x, y) to linear RAM address, addr = y*BOARD_W + x.
module coord_to_addr
  import tetris_pkg::*;
(
  input  logic [3:0] x_i,
  input  logic [4:0] y_i,
  output logic [7:0] addr_o
);

  assign addr_o = 8'(y_i) * 8'(BOARD_W) + 8'(x_i);

endmodule

// File: rtl/row_clear.sv
// Scans the board bottom-up after a piece locks, removing full rows by
// shifting everything above down one row and blanking the top row.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | waiting for start; all outputs quiet
// ST_SCAN_RD   | present address of (col,row) for the fullness scan
// ST_SCAN_CHK  | inspect the read cell; step column, step row, or go shift
// ST_SHIFT_RD  | read cell (col,dst-1)
// ST_SHIFT_WR  | write that value into (col,dst)
// ST_CLEAR_TOP | write empty into row 0, one column per cycle
// ST_FINISH    | one-cycle done pulse, busy low, back to idle
module row_clear
  import tetris_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [5:0] ram_q,
  output logic [7:0] ram_addr,
  output logic [5:0] ram_data,
  output logic       ram_wren,
  output logic       busy,
  output logic       done,
  output logic [2:0] rows_cleared
);

  rc_state_e  state_q, state_d;
  logic [4:0] row_q, row_d;
  logic [3:0] col_q, col_d;
  logic [4:0] dst_q, dst_d;
  logic [2:0] cleared_q, cleared_d;

  logic [3:0] addr_x;
  logic [4:0] addr_y;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      dst_q     <= '0;
      cleared_q <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      dst_q     <= dst_d;
      cleared_q <= cleared_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    dst_d     = dst_q;
    cleared_d = cleared_q;
    addr_x    = '0;
    addr_y    = '0;
    ram_wren  = 1'b0;
    ram_data  = EMPTY_COLOUR;
    busy      = 1'b1;
    done      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          row_d     = BOTTOM_ROW;
          col_d     = '0;
          cleared_d = '0;
          state_d   = ST_SCAN_RD;
        end
      end

      ST_SCAN_RD: begin
        addr_x  = col_q;
        addr_y  = row_q;
        state_d = ST_SCAN_CHK;
      end

      ST_SCAN_CHK: begin
        addr_x = col_q;
        addr_y = row_q;
        if (ram_q == EMPTY_COLOUR) begin
          col_d = '0;
          if (row_q == '0) begin
            state_d = ST_FINISH;
          end else begin
            row_d   = row_q - 5'd1;
            state_d = ST_SCAN_RD;
          end
        end else if (col_q != LAST_COL) begin
          col_d   = col_q + 4'd1;
          state_d = ST_SCAN_RD;
        end else begin
          // Row 0 has nothing above it to pull down.
          dst_d   = row_q;
          col_d   = '0;
          state_d = (row_q == '0) ? ST_CLEAR_TOP : ST_SHIFT_RD;
        end
      end

      ST_SHIFT_RD: begin
        addr_x  = col_q;
        addr_y  = dst_q - 5'd1;
        state_d = ST_SHIFT_WR;
      end

      ST_SHIFT_WR: begin
        addr_x   = col_q;
        addr_y   = dst_q;
        ram_wren = 1'b1;
        ram_data = ram_q;
        if (col_q != LAST_COL) begin
          col_d   = col_q + 4'd1;
          state_d = ST_SHIFT_RD;
        end else begin
          col_d = '0;
          if (dst_q > 5'd1) begin
            dst_d   = dst_q - 5'd1;
            state_d = ST_SHIFT_RD;
          end else begin
            state_d = ST_CLEAR_TOP;
          end
        end
      end

      ST_CLEAR_TOP: begin
        addr_x   = col_q;
        addr_y   = '0;
        ram_wren = 1'b1;
        ram_data = EMPTY_COLOUR;
        if (col_q != LAST_COL) begin
          col_d = col_q + 4'd1;
        end else begin
          // Rescan the same row: whatever dropped into it may also be full.
          col_d     = '0;
          cleared_d = (cleared_q == MAX_CLEARED) ? cleared_q : cleared_q + 3'd1;
          state_d   = ST_SCAN_RD;
        end
      end

      ST_FINISH: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  coord_to_addr u_coord_to_addr (
    .x_i    (addr_x),
    .y_i    (addr_y),
    .addr_o (ram_addr)
  );

  assign rows_cleared = cleared_q;

endmodule

// File: tb/tb_row_clear.sv
// Directed bench for row_clear with a behavioural synchronous board RAM.
module tb_row_clear;

  logic       clk;
  logic       resetn;
  logic       start;
  logic [5:0] ram_q;
  logic [7:0] ram_addr;
  logic [5:0] ram_data;
  logic       ram_wren;
  logic       busy;
  logic       done;
  logic [2:0] rows_cleared;

  int errors = 0;
  int checks = 0;

  logic [5:0] mem   [240];
  logic [5:0] img   [240];
  logic [5:0] exp_b [240];
  logic       load;
  int         wr_cnt;
  int         shift_wr_cnt;
  int         done_cnt;

  row_clear dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .ram_q        (ram_q),
    .ram_addr     (ram_addr),
    .ram_data     (ram_data),
    .ram_wren     (ram_wren),
    .busy         (busy),
    .done         (done),
    .rows_cleared (rows_cleared)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Board RAM: one-cycle read latency; load copies img in and clears counters.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 240; i++) mem[i] <= img[i];
      wr_cnt       <= 0;
      shift_wr_cnt <= 0;
      done_cnt     <= 0;
    end else begin
      if (ram_wren) begin
        if (ram_addr < 8'd240) mem[ram_addr] <= ram_data;
        wr_cnt <= wr_cnt + 1;
        if (ram_addr >= 8'd10) shift_wr_cnt <= shift_wr_cnt + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
    end
    ram_q <= (ram_addr < 8'd240) ? mem[ram_addr] : 6'd0;
  end

  task automatic clear_imgs();
    for (int i = 0; i < 240; i++) begin
      img[i]   = 6'd0;
      exp_b[i] = 6'd0;
    end
  endtask

  task automatic load_board();
    @(posedge clk); #1;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  function automatic int board_diff();
    int n = 0;
    for (int i = 0; i < 240; i++) if (mem[i] !== exp_b[i]) n++;
    return n;
  endfunction

  // Pulses start, then counts edges until done; optional second start at restart_at.
  task automatic run_op(input int restart_at, output int cycles,
                        output logic busy0, output logic busy_done);
    cycles    = -1;
    busy_done = 1'bx;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy0 = busy;
    for (int n = 1; n <= 3000; n++) begin
      start = (n == restart_at);
      @(posedge clk); #1;
      if (done) begin
        cycles    = n;
        busy_done = busy;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic setup_one_row();
    clear_imgs();
    for (int x = 0; x < 10; x++) img[230 + x] = 6'd5;
    img[220]   = 6'd3;
    exp_b[230] = 6'd3;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
    checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %0b expected 0", ram_wren); end
    checks++; if (ram_addr !== 8'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", ram_addr); end
    checks++; if (ram_data !== 6'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", ram_data); end
    checks++; if (rows_cleared !== 3'd0) begin errors++; $display("FAIL reset_rows: got %0d expected 0", rows_cleared); end
    resetn = 1'b1;
  endtask

  task automatic test_empty();
    int cyc; logic b0, bd;
    clear_imgs();
    load_board();
    run_op(0, cyc, b0, bd);
    checks++; if (cyc != 48) begin errors++; $display("FAIL empty_cycles: got %0d expected 48", cyc); end
    checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL empty_busy_rise: got %0b expected 1", b0); end
    checks++; if (bd !== 1'b0) begin errors++; $display("FAIL empty_busy_at_done: got %0b expected 0", bd); end
    checks++; if (wr_cnt != 0) begin errors++; $display("FAIL empty_writes: got %0d expected 0", wr_cnt); end
    checks++; if (rows_cleared !== 3'd0) begin errors++; $display("FAIL empty_rows: got %0d expected 0", rows_cleared); end
  endtask

  task automatic test_one_row();
    int cyc; logic b0, bd;
    setup_one_row();
    load_board();
    run_op(0, cyc, b0, bd);
    checks++; if (cyc != 540) begin errors++; $display("FAIL one_row_cycles: got %0d expected 540", cyc); end
    checks++; if (board_diff() != 0) begin errors++; $display("FAIL one_row_board: got %0d bad cells expected 0", board_diff()); end
    checks++; if (rows_cleared !== 3'd1) begin errors++; $display("FAIL one_row_rows: got %0d expected 1", rows_cleared); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (rows_cleared !== 3'd1) begin errors++; $display("FAIL one_row_rows_held: got %0d expected 1", rows_cleared); end
  endtask

  task automatic test_four_rows();
    int cyc; logic b0, bd;
    clear_imgs();
    for (int i = 200; i < 240; i++) img[i] = 6'd7;
    img[194]   = 6'd2;
    exp_b[234] = 6'd2;
    load_board();
    run_op(0, cyc, b0, bd);
    checks++; if (cyc != 2008) begin errors++; $display("FAIL four_rows_cycles: got %0d expected 2008", cyc); end
    checks++; if (board_diff() != 0) begin errors++; $display("FAIL four_rows_board: got %0d bad cells expected 0", board_diff()); end
    checks++; if (rows_cleared !== 3'd4) begin errors++; $display("FAIL four_rows_rows: got %0d expected 4", rows_cleared); end
  endtask

  task automatic test_row0();
    int cyc; logic b0, bd;
    clear_imgs();
    for (int x = 0; x < 10; x++) img[x] = 6'd1;
    load_board();
    run_op(0, cyc, b0, bd);
    checks++; if (cyc != 78) begin errors++; $display("FAIL row0_cycles: got %0d expected 78", cyc); end
    checks++; if (shift_wr_cnt != 0) begin errors++; $display("FAIL row0_shift_writes: got %0d expected 0", shift_wr_cnt); end
    checks++; if (wr_cnt != 10) begin errors++; $display("FAIL row0_writes: got %0d expected 10", wr_cnt); end
    checks++; if (board_diff() != 0) begin errors++; $display("FAIL row0_board: got %0d bad cells expected 0", board_diff()); end
    checks++; if (rows_cleared !== 3'd1) begin errors++; $display("FAIL row0_rows: got %0d expected 1", rows_cleared); end
  endtask

  task automatic test_back_to_back();
    int cyc; logic b0, bd;
    setup_one_row();
    load_board();
    run_op(100, cyc, b0, bd);
    repeat (20) @(posedge clk);
    #1;
    checks++; if (cyc != 540) begin errors++; $display("FAIL restart_cycles: got %0d expected 540", cyc); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL restart_done_pulses: got %0d expected 1", done_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL restart_idle_busy: got %0b expected 0", busy); end
    checks++; if (board_diff() != 0) begin errors++; $display("FAIL restart_board: got %0d bad cells expected 0", board_diff()); end
    checks++; if (rows_cleared !== 3'd1) begin errors++; $display("FAIL restart_rows: got %0d expected 1", rows_cleared); end
  endtask

  task automatic test_reset_mid();
    int cyc; logic b0, bd; logic found;
    setup_one_row();
    load_board();
    found = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (ram_wren && ram_addr >= 8'd10) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL midreset_reach_shift: got %0b expected 1", found); end
    resetn = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %0b expected 0", busy); end
    checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL midreset_wren: got %0b expected 0", ram_wren); end
    checks++; if (ram_addr !== 8'd0) begin errors++; $display("FAIL midreset_addr: got %0d expected 0", ram_addr); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %0b expected 0", done); end
    resetn = 1'b1;
    setup_one_row();
    load_board();
    run_op(0, cyc, b0, bd);
    checks++; if (cyc != 540) begin errors++; $display("FAIL midreset_rerun_cycles: got %0d expected 540", cyc); end
    checks++; if (board_diff() != 0) begin errors++; $display("FAIL midreset_rerun_board: got %0d bad cells expected 0", board_diff()); end
    checks++; if (rows_cleared !== 3'd1) begin errors++; $display("FAIL midreset_rerun_rows: got %0d expected 1", rows_cleared); end
  endtask

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    load   = 1'b0;
    clear_imgs();
    test_reset();
    test_empty();
    test_one_row();
    test_four_rows();
    test_row0();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
